// File: rtl/shared_bus_responder.sv
// shared_bus_responder: memory-side responder on the L2 shared front-side bus.
// Accepts one line request at a time, samples the snoop result one cycle after
// acceptance, and answers either straight away (HITM forward, invalidate, bad
// opcode) or after LATENCY DRAM wait cycles from a small aliased backing store.
// Optional build macro: SNOOP_WRITEBACK_EN -- HITM data on "R"/"M" is also
// written into the backing store.
//
// state | meaning
// IDLE  | ready for a request
// SNOOP | one cycle, snoop_result sampled, path chosen
// WAIT  | DRAM latency countdown, store access on terminal count
// RESP  | response presented until rsp_ready
module shared_bus_responder #(
  parameter int ADDR_BITS  = 32,
  parameter int LINE_SIZE  = 512,
  parameter int DEPTH_BITS = 4,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LINE_SIZE-1:0] req_data,
  input  logic [1:0]           snoop_result,
  input  logic [LINE_SIZE-1:0] snoop_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [LINE_SIZE-1:0] rsp_data,
  output logic [1:0]           rsp_snoop,
  output logic                 rsp_err
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_M = 8'h4D;
  localparam logic [7:0] OP_I = 8'h49;
  localparam logic [1:0] SNP_HITM = 2'b10;

  typedef enum logic [1:0] {IDLE, SNOOP, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              op_q, op_d;
  logic [DEPTH_BITS-1:0]   idx_q, idx_d;
  logic [LINE_SIZE-1:0]    wdata_q, wdata_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [LINE_SIZE-1:0]    rsp_data_q, rsp_data_d;
  logic [1:0]              rsp_snoop_q, rsp_snoop_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [LINE_SIZE-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;
  logic                    mem_we;
  logic [LINE_SIZE-1:0]    mem_wdata;

  logic                    is_read;
  logic                    op_known;

  // Only the line index bits take part; the rest are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[ADDR_BITS-1:DEPTH_BITS+6], req_addr[5:0]};

  assign is_read  = (op_q == OP_R) || (op_q == OP_M);
  assign op_known = is_read || (op_q == OP_W) || (op_q == OP_I);

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_snoop = rsp_snoop_q;
  assign rsp_err   = rsp_err_q;

  // Next-state, response capture and store write-enable decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_snoop_d = rsp_snoop_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_wdata   = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          idx_d   = req_addr[DEPTH_BITS+5:6];
          wdata_d = req_data;
          state_d = SNOOP;
        end
      end
      SNOOP: begin
        rsp_snoop_d = snoop_result;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        if (!op_known) begin
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end else if (op_q == OP_I) begin
          state_d = RESP;
        end else if (is_read && (snoop_result == SNP_HITM)) begin
          rsp_data_d = snoop_data;
          state_d    = RESP;
`ifdef SNOOP_WRITEBACK_EN
          mem_we    = 1'b1;
          mem_wdata = snoop_data;
`endif
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          if (op_q == OP_W) begin
            mem_we     = 1'b1;
            rsp_data_d = '0;
          end else begin
            rsp_data_d = valid_q[idx_q] ? mem_q[idx_q] : '0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_snoop_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_snoop_q <= rsp_snoop_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Valid bits; cleared by reset so stale lines read back as zero.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else if (mem_we) valid_q[idx_q] <= 1'b1;
  end

  // Line storage, no reset needed because valid_q gates every read.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[idx_q] <= mem_wdata;
  end

endmodule

// File: tb/tb_shared_bus_responder.sv
// Self-checking bench for shared_bus_responder: directed scenarios followed by
// random traffic, compared against a line-level model of the backing store.
module tb_shared_bus_responder;

  localparam int LAT = 4;
  localparam int LS  = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_op = 8'h00;
  logic [31:0]   req_addr = '0;
  logic [LS-1:0] req_data = '0;
  logic [1:0]    snoop_result = 2'b00;
  logic [LS-1:0] snoop_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [LS-1:0] rsp_data;
  logic [1:0]    rsp_snoop;
  logic          rsp_err;

  int errors = 0;
  int checks = 0;

  logic [LS-1:0] model_mem [16];
  bit            model_vld [16];

  shared_bus_responder #(.ADDR_BITS(32), .LINE_SIZE(LS), .DEPTH_BITS(4), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .snoop_result(snoop_result), .snoop_data(snoop_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_snoop(rsp_snoop), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LS-1:0] got, input logic [LS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LS-1:0] rand_line();
    logic [LS-1:0] v;
    for (int i = 0; i < LS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full transaction: model predicts, DUT is driven, response checked.
  task automatic do_req(input logic [7:0] op, input logic [31:0] addr, input logic [LS-1:0] data,
                        input logic [1:0] snp, input logic [LS-1:0] sdata,
                        input int stall, input bit hold_req);
    int idx;
    int exp_lat;
    int n;
    logic [LS-1:0] exp_data;
    logic exp_err;
    logic [LS-1:0] held;
    idx = int'(addr[9:6]);
    exp_err  = 1'b0;
    exp_data = '0;
    exp_lat  = 1;
    if (op == "R" || op == "M") begin
      if (snp == 2'b10) begin
        exp_data = sdata;
`ifdef SNOOP_WRITEBACK_EN
        model_mem[idx] = sdata;
        model_vld[idx] = 1'b1;
`endif
      end else begin
        exp_lat  = LAT + 1;
        exp_data = model_vld[idx] ? model_mem[idx] : '0;
      end
    end else if (op == "W") begin
      exp_lat = LAT + 1;
      model_mem[idx] = data;
      model_vld[idx] = 1'b1;
    end else if (op != "I") begin
      exp_err = 1'b1;
    end

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    snoop_result = snp; snoop_data = sdata;
    @(posedge clk);
    #1;
    if (!hold_req) req_valid = 1'b0;
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      #1;
      if (rsp_valid || n > 300) break;
    end
    chk("latency", n, exp_lat);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_snoop", rsp_snoop, snp);
    chk("rsp_err", rsp_err, exp_err);
    held = rsp_data;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, held);
      chk("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_idle", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = '0;
      model_vld[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_snoop", rsp_snoop, 2'b00);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", req_ready, 1);

    do_req("R", 32'h40, '0, 2'b00, '0, 0, 1'b0);
    do_req("W", 32'h80, {64{8'hA5}}, 2'b00, '0, 0, 1'b0);
    do_req("R", 32'h80, '0, 2'b00, '0, 0, 1'b0);
    do_req("R", 32'h480, '0, 2'b01, '0, 0, 1'b0);
    do_req("R", 32'hC0, '0, 2'b10, {64{8'h3C}}, 0, 1'b0);
    do_req("R", 32'hC0, '0, 2'b00, '0, 0, 1'b0);
    do_req("R", 32'h80, '0, 2'b00, '0, 5, 1'b1);
    do_req("X", 32'h80, rand_line(), 2'b00, '0, 0, 1'b0);
    do_req("I", 32'h80, rand_line(), 2'b00, '0, 0, 1'b0);
    do_req("R", 32'h80, '0, 2'b00, '0, 0, 1'b0);
    do_req("W", 32'h40, rand_line(), 2'b10, rand_line(), 1, 1'b0);
    do_req("M", 32'h40, '0, 2'b11, rand_line(), 0, 1'b0);

    // Reset in the middle of a write-back's WAIT phase.
    @(negedge clk);
    req_valid = 1'b1; req_op = "W"; req_addr = 32'h100; req_data = {64{8'h77}};
    snoop_result = 2'b00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model_vld[i] = 1'b0;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    chk("midrst_idle", req_ready, 1);
    do_req("R", 32'h100, '0, 2'b00, '0, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      logic [7:0] op;
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0, 1, 2: op = "R";
        3, 4, 5: op = "W";
        6, 7:    op = "M";
        8:       op = "I";
        default: op = 8'($urandom_range(0, 255));
      endcase
      a = $urandom;
      do_req(op, a, rand_line(), 2'($urandom_range(0, 3)), rand_line(),
             $urandom_range(0, 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
